// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction fields, write-enable decode.
// WRITEBACK_ZERO_REG_EN: when defined, results targeting r0 are retired without a write.
package cpu_pkg;

    localparam logic [4:0] OP_LW  = 5'd0;
    localparam logic [4:0] OP_SW  = 5'd1;
    localparam logic [4:0] OP_MOV = 5'd2;
    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;
    localparam logic [4:0] OP_OR  = 5'd8;
    localparam logic [4:0] OP_SHL = 5'd9;
    localparam logic [4:0] OP_SHR = 5'd10;
    localparam logic [4:0] OP_CMP = 5'd11;
    localparam logic [4:0] OP_NOT = 5'd12;

    localparam int OP_LSB = 27;
    localparam int RD_LSB = 22;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
    } wb_entry_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OP_LSB +: 5];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[RD_LSB +: 5];
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
        case (op)
            OP_LW, OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT: return 1'b1;
            OP_SW, OP_CMP:                         return 1'b0;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic entry_writes(input logic [31:0] instr);
`ifdef WRITEBACK_ZERO_REG_EN
        return writes_reg(opcode_of(instr)) && (rd_of(instr) != 5'd0);
`else
        return writes_reg(opcode_of(instr));
`endif
    endfunction

    function automatic logic [31:0] wr_mask(input logic [31:0] instr);
        return entry_writes(instr) ? (32'd1 << rd_of(instr)) : 32'd0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular result queue with a pending-destination vector over occupied slots.
// Latency: pushed entry visible at head the edge after push.
// Backpressure: none internally; caller must not push when count==DEPTH.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic [31:0]   pend_mask
);

    wb_entry_t         slots [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_entry;
    end

    assign head = slots[rd_ptr];

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        pend_mask = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < count) pend_mask = pend_mask | wr_mask(slots[i].instr);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU/load results into a queue and issues one register-file write per cycle.
// Latency: 2 edges from accept to rf_* on an empty queue; 1 write/cycle sustained.
// Backpressure: ready low when queue full, in reset, or channel loses round-robin. Macro WRITEBACK_ZERO_REG_EN (cpu_pkg).
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [31:0] alu_instr,
    input  logic [31:0] alu_result,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_instr,
    input  logic [31:0] mem_data,
    output logic [31:0] rf_data,
    output logic [31:0] rf_instr,
    output logic        rf_enable_write,
    output logic [31:0] pending_mask,
    output logic        empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic          full;
    logic          rr_mem;
    logic          out_vld;
    logic          push;
    logic          pop;
    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic [31:0]   q_pend;

    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0);

    // rr_mem set: mem wins the next contended cycle.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n && !full) begin
            mem_ready = mem_valid && (!alu_valid || rr_mem);
            alu_ready = alu_valid && (!mem_valid || !rr_mem);
        end
    end

    assign push       = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign push_entry = mem_ready ? wb_entry_t'{instr: mem_instr, data: mem_data}
                                  : wb_entry_t'{instr: alu_instr, data: alu_result};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .pend_mask  (q_pend)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_data         <= '0;
            rf_instr        <= '0;
            rf_enable_write <= 1'b0;
            out_vld         <= 1'b0;
            rr_mem          <= 1'b1;
        end else begin
            out_vld         <= pop;
            rf_enable_write <= pop && entry_writes(head.instr);
            if (pop) begin
                rf_instr <= head.instr;
                rf_data  <= (opcode_of(head.instr) == OP_MOV) ? 32'd0 : head.data;
            end
            if (alu_valid && mem_valid && !full) rr_mem <= !rr_mem;
        end
    end

    assign pending_mask = q_pend | (rf_enable_write ? (32'd1 << rd_of(rf_instr)) : 32'd0);
    assign empty        = (count == '0) && !out_vld;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model plus directed literal checks.
module tb_writeback_unit;

    localparam int DEPTH = 4;
    // Writing opcodes as a membership set: LW, MOV..SHR, NOT.
    localparam logic [31:0] WR_OPS = 32'h0000_17FD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [31:0] alu_instr = '0, alu_result = '0, mem_instr = '0, mem_data = '0;
    logic [31:0] rf_data, rf_instr, pending_mask;
    logic        rf_enable_write, empty;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_instr(alu_instr), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_data(mem_data),
        .rf_data(rf_data), .rf_instr(rf_instr), .rf_enable_write(rf_enable_write),
        .pending_mask(pending_mask), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mq[$];
    bit          m_rr_mem = 1'b1;
    bit [31:0]   m_data = '0, m_instr = '0;
    bit          m_we = 1'b0, m_outvld = 1'b0;
    bit          ga_m, gm_m, ga_c, gm_c;
    logic [63:0] m_e;

    function automatic bit m_writes(input bit [31:0] ins);
        bit [31:0] ops = WR_OPS;
        bit [4:0]  op = ins[31:27];
        bit        w = ops[op];
`ifdef WRITEBACK_ZERO_REG_EN
        if (ins[26:22] == 5'd0) w = 1'b0;
`endif
        return w;
    endfunction

    function automatic bit [31:0] m_pend();
        bit [31:0] p = '0;
        foreach (mq[i]) if (m_writes(mq[i][63:32])) p[mq[i][58:54]] = 1'b1;
        if (m_we) p[m_instr[26:22]] = 1'b1;
        return p;
    endfunction

    task automatic model_grants(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (rst_n && mq.size() < DEPTH) begin
            if (alu_valid && mem_valid) begin
                if (m_rr_mem) gm = 1'b1; else ga = 1'b1;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_rr_mem = 1'b1;
            m_data = '0; m_instr = '0; m_we = 1'b0; m_outvld = 1'b0;
        end else begin
            model_grants(ga_m, gm_m);
            if (ga_m || gm_m) begin
                if (alu_valid && mem_valid) m_rr_mem = !m_rr_mem;
            end
            if (mq.size() > 0) begin
                m_e = mq.pop_front();
                m_instr  = m_e[63:32];
                m_data   = (m_e[63:59] == 5'd2) ? 32'd0 : m_e[31:0];
                m_we     = m_writes(m_instr);
                m_outvld = 1'b1;
            end else begin
                m_we = 1'b0;
                m_outvld = 1'b0;
            end
            if (gm_m)      mq.push_back({mem_instr, mem_data});
            else if (ga_m) mq.push_back({alu_instr, alu_result});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            model_grants(ga_c, gm_c);
            check("alu_ready",       32'(alu_ready),       32'(ga_c));
            check("mem_ready",       32'(mem_ready),       32'(gm_c));
            check("rf_enable_write", 32'(rf_enable_write), 32'(m_we));
            check("rf_data",         rf_data,              m_data);
            check("rf_instr",        rf_instr,             m_instr);
            check("pending_mask",    pending_mask,         m_pend());
            check("empty",           32'(empty),           32'(mq.size() == 0 && !m_outvld));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_empty",   32'(empty), 32'd1);
        check("reset_we",      32'(rf_enable_write), 32'd0);
        check("reset_pending", pending_mask, 32'd0);
        check("reset_rf_data", rf_data, 32'd0);
        check("reset_alu_rdy", 32'(alu_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ADD r1
        alu_valid = 1'b1; alu_instr = 32'h1840_0000; alu_result = 32'h1234_5678;
        #1 check("add_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        check("add_pend_q",  pending_mask, 32'h0000_0002);
        check("add_we_early", 32'(rf_enable_write), 32'd0);
        tick();
        check("add_we",      32'(rf_enable_write), 32'd1);
        check("add_data",    rf_data, 32'h1234_5678);
        check("add_pend_out", pending_mask, 32'h0000_0002);
        tick();
        check("add_we_drop", 32'(rf_enable_write), 32'd0);
        check("add_pend_clr", pending_mask, 32'd0);
        check("add_empty",   32'(empty), 32'd1);

        // SW then CMP: retired without writes
        mem_valid = 1'b1; mem_instr = 32'h0940_0003; mem_data = 32'h0000_00AA;
        tick();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_instr = 32'h5980_0001; alu_result = 32'h0000_0055;
        check("sw_pend", pending_mask, 32'd0);
        tick();
        idle();
        check("sw_we",   32'(rf_enable_write), 32'd0);
        check("cmp_pend", pending_mask, 32'd0);
        tick();
        check("cmp_we",  32'(rf_enable_write), 32'd0);
        check("cmp_instr", rf_instr, 32'h5980_0001);
        tick();

        // Two ADDs to r5
        alu_valid = 1'b1; alu_instr = 32'h1940_0000; alu_result = 32'h0000_0011;
        tick();
        alu_result = 32'h0000_0022;
        tick();
        idle();
        check("r5_pend_a", pending_mask, 32'h0000_0020);
        tick();
        check("r5_pend_b", pending_mask, 32'h0000_0020);
        check("r5_data_b", rf_data, 32'h0000_0022);
        tick();
        check("r5_pend_clr", pending_mask, 32'd0);

        // LW to r0 with 0xDEADBEEF
        mem_valid = 1'b1; mem_instr = 32'h0000_0000; mem_data = 32'hDEAD_BEEF;
        tick();
        idle();
        tick();
`ifdef WRITEBACK_ZERO_REG_EN
        check("r0_we", 32'(rf_enable_write), 32'd0);
        check("r0_pend", pending_mask, 32'd0);
`else
        check("r0_we", 32'(rf_enable_write), 32'd1);
        check("r0_pend", pending_mask, 32'd1);
`endif
        check("r0_data", rf_data, 32'hDEAD_BEEF);
        tick();

        // Contended traffic: mem wins first, then alternate
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_instr = 32'h1880_0000; alu_result = 32'hA000_0000 + 32'(c);
            mem_valid = 1'b1; mem_instr = 32'h00C0_0000; mem_data   = 32'hB000_0000 + 32'(c);
            #1;
            if (c == 0) check("rr_first_mem", {31'd0, mem_ready}, 32'd1);
            if (c == 1) check("rr_then_alu",  {31'd0, alu_ready}, 32'd1);
            if (c == 2) check("rr_back_mem",  {31'd0, mem_ready}, 32'd1);
            tick();
        end

        // Reset mid-burst
        rst_n = 1'b0;
        #1 check("rst_rdy", {30'd0, alu_ready, mem_ready}, 32'd0);
        tick();
        check("rst_empty",   32'(empty), 32'd1);
        check("rst_we",      32'(rf_enable_write), 32'd0);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_data",    rf_data, 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            alu_valid  = ($urandom_range(0, 99) < 60);
            mem_valid  = ($urandom_range(0, 99) < 60);
            alu_instr  = {($urandom_range(0, 3) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12)),
                          5'($urandom_range(0, 7)), 22'($urandom)};
            mem_instr  = {($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 7)), 22'($urandom)};
            alu_result = $urandom;
            mem_data   = $urandom;
            rst_n      = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
